// File: rtl/parking_billing_pkg.sv
// Shared types and constants for the parking billing block.
// Fee helper saturates the tariff sum to the 10-bit display range.
package parking_billing_pkg;

   localparam int TIME_W = 10;
   localparam logic [9:0] FEE_MAX = 10'd1023;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      SETTLE = 2'd2
   } state_e;

   function automatic logic [9:0] fee_calc(
      input logic [9:0] base,
      input logic [9:0] per,
      input logic [9:0] dur
   );
      logic [19:0] prod;
      logic [20:0] sum;
      prod = 20'(per) * 20'(dur);
      sum  = 21'(base) + 21'(prod);
      return (sum > 21'(FEE_MAX)) ? FEE_MAX : sum[9:0];
   endfunction

endpackage

// File: rtl/parking_billing_edge_pulse.sv
// Two-flop rising-edge detector for debounced level inputs.
// The pulse is high for the one cycle after the edge is sampled.
module parking_billing_edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic p_o
);

   logic q1_q, q2_q;

   // Sample the level and keep one cycle of history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_q <= 1'b0;
         q2_q <= 1'b0;
      end else begin
         q1_q <= d_i;
         q2_q <= q1_q;
      end
   end

   assign p_o = q1_q & ~q2_q;

endmodule

// File: rtl/parking_billing.sv
// Per-slot session tracking and exit fee settlement.
// Optional free-parking window: define PARK_GRACE_EN.
module parking_billing
   import parking_billing_pkg::*;
#(
   parameter int MAX_SLOTS   = 16,
   parameter int SLOT_W      = 4,
   parameter int TICK_DIV    = 100000000,
   parameter int GRACE_TICKS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              car_in,
   input  logic              car_vip,
   input  logic              car_out,
   input  logic [SLOT_W-1:0] slot_sel,
   input  logic [9:0]        initial_money,
   input  logic [9:0]        per_money,
   input  logic [9:0]        initial_vipmoney,
   input  logic [9:0]        num_of_park,
   input  logic              empty,
   output logic [9:0]        moneyget,
   output logic [9:0]        timeget,
   output logic              swm,
   output logic [SLOT_W-1:0] assigned_slot,
   output logic [SLOT_W:0]   occupied,
   output logic              full,
   output logic              err
);

`ifdef PARK_GRACE_EN
   localparam bit GRACE_EN = 1'b1;
`else
   localparam bit GRACE_EN = 1'b0;
`endif

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [9:0] MAXS = 10'(MAX_SLOTS);
   localparam logic [9:0] GRACE = 10'(GRACE_TICKS);

   logic in_p, out_p, emp_p;

   state_e state_q, state_d;
   logic [TW-1:0]     tick_q;
   logic [TIME_W-1:0] now_q;

   logic [MAX_SLOTS-1:0] occ_q, occ_d;
   logic [MAX_SLOTS-1:0] vip_q, vip_d;
   logic [TIME_W-1:0]    ent_q [MAX_SLOTS];
   logic [TIME_W-1:0]    ent_d [MAX_SLOTS];

   logic [SLOT_W:0]   occn_q, occn_d;
   logic [SLOT_W-1:0] sel_q, asg_q;
   logic [9:0]        fee_q, dur_q;
   logic              err_q;

   logic [9:0]        cap;
   logic              free_ok;
   logic [SLOT_W-1:0] free_idx;
   logic              ent_ok, ent_rej;
   logic              sel_ok, ext_ok, ext_rej;
   logic              settle;
   logic [9:0]        dur_c, base_c, fee_c;

   parking_billing_edge_pulse u_in (
      .clk(clk), .rst_n(rst), .d_i(car_in), .p_o(in_p)
   );
   parking_billing_edge_pulse u_out (
      .clk(clk), .rst_n(rst), .d_i(car_out), .p_o(out_p)
   );
   parking_billing_edge_pulse u_emp (
      .clk(clk), .rst_n(rst), .d_i(empty), .p_o(emp_p)
   );

   assign cap = (num_of_park > MAXS) ? MAXS : num_of_park;

   // Lowest free slot below the effective capacity.
   always_comb begin
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
         if (!occ_q[i] && (i < int'(cap))) begin
            free_ok  = 1'b1;
            free_idx = SLOT_W'(i);
         end
      end
   end

   assign ent_ok  = in_p & ~emp_p & (10'(occn_q) < cap) & free_ok;
   assign ent_rej = in_p & ~emp_p & ~ent_ok;
   assign sel_ok  = {1'b0, slot_sel} < (SLOT_W+1)'(MAX_SLOTS);
   assign ext_ok  = out_p & ~emp_p & (state_q == IDLE)
                  & sel_ok & occ_q[slot_sel];
   assign ext_rej = out_p & ~emp_p & ~ext_ok;
   assign settle  = (state_q == SETTLE) & ~emp_p;

   assign dur_c  = now_q - ent_q[sel_q];
   assign base_c = vip_q[sel_q] ? initial_vipmoney : initial_money;
   assign fee_c  = (GRACE_EN && (dur_c <= GRACE)) ? 10'd0
                 : fee_calc(base_c, per_money, dur_c);

   // Settlement sequencing; a clear command always lands in IDLE.
   always_comb begin
      state_d = state_q;
      if (emp_p) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (ext_ok) state_d = CALC;
            CALC:    state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Slot table and car count next state.
   always_comb begin
      occ_d  = occ_q;
      vip_d  = vip_q;
      ent_d  = ent_q;
      occn_d = occn_q;
      if (emp_p) begin
         occ_d  = '0;
         occn_d = '0;
      end else begin
         if (settle) occ_d[sel_q] = 1'b0;
         if (ent_ok) begin
            occ_d[free_idx] = 1'b1;
            vip_d[free_idx] = car_vip;
            ent_d[free_idx] = now_q;
         end
         occn_d = occn_q + (SLOT_W+1)'(ent_ok)
                - (SLOT_W+1)'(settle);
      end
   end

   // Free-running timebase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q <= '0;
         now_q  <= '0;
      end else if (tick_q == TW'(TICK_DIV - 1)) begin
         tick_q <= '0;
         now_q  <= now_q + 1'b1;
      end else begin
         tick_q <= tick_q + 1'b1;
      end
   end

   // State, table and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         occ_q   <= '0;
         vip_q   <= '0;
         ent_q   <= '{default: '0};
         occn_q  <= '0;
         sel_q   <= '0;
         asg_q   <= '0;
         fee_q   <= '0;
         dur_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         vip_q   <= vip_d;
         ent_q   <= ent_d;
         occn_q  <= occn_d;
         err_q   <= ent_rej | ext_rej;
         if (ext_ok) sel_q <= slot_sel;
         if (ent_ok) asg_q <= free_idx;
         if ((state_q == CALC) && !emp_p) begin
            fee_q <= fee_c;
            dur_q <= dur_c;
         end
      end
   end

   assign moneyget      = fee_q;
   assign timeget       = dur_q;
   assign swm           = settle;
   assign assigned_slot = asg_q;
   assign occupied      = occn_q;
   assign full          = 10'(occn_q) >= cap;
   assign err           = err_q;

endmodule
